// File: rtl/ahb_interconnect_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_interconnect_if
// Brief    : Master-side and slave-side AHB-Lite signal bundle of the
//            single-master, N-slave interconnect.
// Revision : 1.0
// ============================================================================
interface ahb_interconnect_if #(
   parameter int NUM_SLAVES = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // Master side
   logic [ADDR_WIDTH-1:0]            m_haddr_in;
   logic [1:0]                       m_htrans_in;
   logic                             m_hwrite_in;
   logic [2:0]                       m_hsize_in;
   logic [2:0]                       m_hburst_in;
   logic [3:0]                       m_hprot_in;
   logic                             m_hmastlock_in;
   logic [DATA_WIDTH-1:0]            m_hwdata_in;
   logic [DATA_WIDTH-1:0]            m_hrdata_out;
   logic                             m_hready_out;
   logic                             m_hresp_out;

   // Slave side
   logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_base_addr_in;
   logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_last_addr_in;
   logic [NUM_SLAVES-1:0]            s_hsel_out;
   logic [ADDR_WIDTH-1:0]            s_haddr_out;
   logic [1:0]                       s_htrans_out;
   logic                             s_hwrite_out;
   logic [2:0]                       s_hsize_out;
   logic [2:0]                       s_hburst_out;
   logic [3:0]                       s_hprot_out;
   logic                             s_hmastlock_out;
   logic [DATA_WIDTH-1:0]            s_hwdata_out;
   logic                             s_hready_out;
   logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hrdata_in;
   logic [NUM_SLAVES-1:0]            s_hready_in;
   logic [NUM_SLAVES-1:0]            s_hresp_in;
   logic [NUM_SLAVES-1:0]            timeout_flag_out;

   // Interconnect view
   modport slave (
      input  m_haddr_in, m_htrans_in, m_hwrite_in, m_hsize_in, m_hburst_in,
             m_hprot_in, m_hmastlock_in, m_hwdata_in,
      output m_hrdata_out, m_hready_out, m_hresp_out,
      input  s_base_addr_in, s_last_addr_in,
      output s_hsel_out, s_haddr_out, s_htrans_out, s_hwrite_out, s_hsize_out,
             s_hburst_out, s_hprot_out, s_hmastlock_out, s_hwdata_out,
             s_hready_out,
      input  s_hrdata_in, s_hready_in, s_hresp_in,
      output timeout_flag_out
   );

   // Environment view: bus master plus attached slaves
   modport master (
      output m_haddr_in, m_htrans_in, m_hwrite_in, m_hsize_in, m_hburst_in,
             m_hprot_in, m_hmastlock_in, m_hwdata_in,
      input  m_hrdata_out, m_hready_out, m_hresp_out,
      output s_base_addr_in, s_last_addr_in,
      input  s_hsel_out, s_haddr_out, s_htrans_out, s_hwrite_out, s_hsize_out,
             s_hburst_out, s_hprot_out, s_hmastlock_out, s_hwdata_out,
             s_hready_out,
      output s_hrdata_in, s_hready_in, s_hresp_in,
      input  timeout_flag_out
   );
endinterface
`default_nettype wire

// File: rtl/ahb_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : ahb_interconnect
// Brief    : Single-master AHB-Lite interconnect with range decoder, default
//            ERROR slave and per-slave HREADY watchdog with quarantine.
// Revision : 1.0
// ============================================================================
module ahb_interconnect #(
   parameter int NUM_SLAVES     = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input wire                HCLK,
   input wire                HRESETn,
   ahb_interconnect_if.slave bus
);

   localparam int                 c_idx_w   = $clog2(NUM_SLAVES + 1);
   localparam logic [c_idx_w-1:0] c_default = c_idx_w'(NUM_SLAVES);
   localparam int                 c_cnt_w   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dflt_state_t;
   typedef enum logic [1:0] {W_RUN, W_ABT1, W_ABT2} wd_state_t;

   logic [NUM_SLAVES-1:0] w_hit;
   logic [NUM_SLAVES-1:0] w_hsel;
   logic [c_idx_w-1:0]    w_target;
   logic [NUM_SLAVES-1:0] r_timeout_flag;

   logic                  r_dvalid;
   logic [c_idx_w-1:0]    r_dtarget;

   logic                  w_dslave;
   logic [NUM_SLAVES-1:0] w_dsel_onehot;
   logic                  w_sel_hready;
   logic                  w_sel_hresp;
   logic [DATA_WIDTH-1:0] w_sel_hrdata;

   dflt_state_t           r_d_state;
   logic                  r_d_hready;
   logic                  r_d_hresp;
   logic                  w_d_start;

   logic                  w_wd_abort;
   logic                  w_wd_hready;

   logic                  w_hready;
   logic                  w_hresp;
   logic [DATA_WIDTH-1:0] w_hrdata;

   // ---------------------------------------------------------------- decode
   // A quarantined slave never hits, so its range falls through to default.
   for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_hit
      logic [ADDR_WIDTH-1:0] w_base;
      logic [ADDR_WIDTH-1:0] w_last;
      assign w_base    = bus.s_base_addr_in[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_last    = bus.s_last_addr_in[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_hit[gi] = (bus.m_haddr_in >= w_base) && (bus.m_haddr_in <= w_last)
                         && !r_timeout_flag[gi];
   end

   // Scanning downwards leaves the lowest hitting index as the winner.
   always_comb begin
      w_target = c_default;
      w_hsel   = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_target  = c_idx_w'(i);
            w_hsel    = '0;
            w_hsel[i] = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------- broadcast
   assign bus.s_hsel_out       = w_hsel;
   assign bus.s_haddr_out      = bus.m_haddr_in;
   assign bus.s_htrans_out     = bus.m_htrans_in;
   assign bus.s_hwrite_out     = bus.m_hwrite_in;
   assign bus.s_hsize_out      = bus.m_hsize_in;
   assign bus.s_hburst_out     = bus.m_hburst_in;
   assign bus.s_hprot_out      = bus.m_hprot_in;
   assign bus.s_hmastlock_out  = bus.m_hmastlock_in;
   assign bus.s_hwdata_out     = bus.m_hwdata_in;
   assign bus.s_hready_out     = w_hready;
   assign bus.m_hready_out     = w_hready;
   assign bus.m_hresp_out      = w_hresp;
   assign bus.m_hrdata_out     = w_hrdata;
   assign bus.timeout_flag_out = r_timeout_flag;

   // ---------------------------------------------------- data-phase select
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_dvalid  <= 1'b0;
         r_dtarget <= c_default;
      end else if (w_hready) begin
         r_dvalid  <= bus.m_htrans_in[1];
         r_dtarget <= w_target;
      end
   end

   always_comb begin
      w_dslave      = 1'b0;
      w_dsel_onehot = '0;
      w_sel_hready  = 1'b1;
      w_sel_hresp   = 1'b0;
      w_sel_hrdata  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_dvalid && (r_dtarget == c_idx_w'(i))) begin
            w_dslave         = 1'b1;
            w_dsel_onehot[i] = 1'b1;
            w_sel_hready     = bus.s_hready_in[i];
            w_sel_hresp      = bus.s_hresp_in[i];
            w_sel_hrdata     = bus.s_hrdata_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // --------------------------------------------------------- default slave
   assign w_d_start = w_hready && bus.m_htrans_in[1] && (w_target == c_default);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_d_state  <= D_IDLE;
         r_d_hready <= 1'b1;
         r_d_hresp  <= 1'b0;
      end else begin
         case (r_d_state)
            D_IDLE: begin
               if (w_d_start) begin
                  r_d_state  <= D_ERR1;
                  r_d_hready <= 1'b0;
                  r_d_hresp  <= 1'b1;
               end
            end
            D_ERR1: begin
               r_d_state  <= D_ERR2;
               r_d_hready <= 1'b1;
               r_d_hresp  <= 1'b1;
            end
            D_ERR2: begin
               // The second ERROR cycle accepts the next address phase.
               if (w_d_start) begin
                  r_d_state  <= D_ERR1;
                  r_d_hready <= 1'b0;
                  r_d_hresp  <= 1'b1;
               end else begin
                  r_d_state  <= D_IDLE;
                  r_d_hready <= 1'b1;
                  r_d_hresp  <= 1'b0;
               end
            end
            default: begin
               r_d_state  <= D_IDLE;
               r_d_hready <= 1'b1;
               r_d_hresp  <= 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------- watchdog
   if (TIMEOUT_CYCLES > 0) begin : g_wd
      wd_state_t          r_wd_state;
      logic [c_cnt_w-1:0] r_wd_cnt;
      logic               r_wd_abort;
      logic               r_wd_hready;

      always_ff @(posedge HCLK or negedge HRESETn) begin
         if (!HRESETn) begin
            r_wd_state     <= W_RUN;
            r_wd_cnt       <= '0;
            r_wd_abort     <= 1'b0;
            r_wd_hready    <= 1'b1;
            r_timeout_flag <= '0;
         end else begin
            case (r_wd_state)
               W_RUN: begin
                  // Only pure wait states count; a slave ERROR cycle wins.
                  if (w_dslave && !w_sel_hready && !w_sel_hresp) begin
                     if (r_wd_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1)) begin
                        r_wd_state     <= W_ABT1;
                        r_wd_cnt       <= '0;
                        r_wd_abort     <= 1'b1;
                        r_wd_hready    <= 1'b0;
                        r_timeout_flag <= r_timeout_flag | w_dsel_onehot;
                     end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                     end
                  end else begin
                     r_wd_cnt <= '0;
                  end
               end
               W_ABT1: begin
                  r_wd_state  <= W_ABT2;
                  r_wd_hready <= 1'b1;
               end
               W_ABT2: begin
                  r_wd_state <= W_RUN;
                  r_wd_abort <= 1'b0;
               end
               default: begin
                  r_wd_state  <= W_RUN;
                  r_wd_abort  <= 1'b0;
                  r_wd_hready <= 1'b1;
               end
            endcase
         end
      end

      assign w_wd_abort  = r_wd_abort;
      assign w_wd_hready = r_wd_hready;
   end else begin : g_no_wd
      assign w_wd_abort     = 1'b0;
      assign w_wd_hready    = 1'b1;
      assign r_timeout_flag = '0;
   end

   // ---------------------------------------------------------- response mux
   always_comb begin
      w_hready = 1'b1;
      w_hresp  = 1'b0;
      w_hrdata = '0;
      if (w_wd_abort) begin
         w_hready = w_wd_hready;
         w_hresp  = 1'b1;
      end else if (w_dslave) begin
         w_hready = w_sel_hready;
         w_hresp  = w_sel_hresp;
         w_hrdata = w_sel_hrdata;
      end else if (r_dvalid) begin
         w_hready = r_d_hready;
         w_hresp  = r_d_hresp;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ahb_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_interconnect
// Brief    : Self-checking bench: decode vector table, directed transfers and
//            randomized transfers against a transaction-level response model.
// Revision : 1.0
// ============================================================================
module tb_ahb_interconnect;

   localparam int NS      = 2;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 8;

   logic clk;
   logic rst_n;

   int checks = 0;
   int errors = 0;

   ahb_interconnect_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ahb_interconnect #(
      .NUM_SLAVES    (NS),
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .HCLK   (clk),
      .HRESETn(rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic        hready;
      logic        hresp;
      bit          rd_care;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] base1;
      logic [1:0]  hsel;
   } dec_vec_t;

   logic [31:0] base [NS];
   logic [31:0] last [NS];
   bit   [1:0]  mflag;
   exp_t        exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply_ranges();
      bus.s_base_addr_in = {base[1], base[0]};
      bus.s_last_addr_in = {last[1], last[0]};
   endtask

   task automatic idle_slaves();
      bus.s_hready_in = '1;
      bus.s_hresp_in  = '0;
      bus.s_hrdata_in = {32'h1111_2222, 32'h3333_4444};
   endtask

   // Address map rule: lowest-index range that contains the address and is
   // not quarantined; -1 means the default slave.
   function automatic int model_target(input logic [31:0] a);
      for (int i = 0; i < NS; i++)
         if (a >= base[i] && a <= last[i] && !mflag[i]) return i;
      return -1;
   endfunction

   // Master-visible data-phase response, one entry per cycle.
   task automatic model_resp(input int tgt, input int waits, input bit err, input logic [31:0] rd);
      exp_q.delete();
      if (tgt < 0) begin
         exp_q.push_back('{1'b0, 1'b1, 1'b0, 32'h0});
         exp_q.push_back('{1'b1, 1'b1, 1'b0, 32'h0});
      end else if (waits >= TIMEOUT) begin
         repeat (TIMEOUT) exp_q.push_back('{1'b0, 1'b0, 1'b0, 32'h0});
         exp_q.push_back('{1'b0, 1'b1, 1'b1, 32'h0});
         exp_q.push_back('{1'b1, 1'b1, 1'b1, 32'h0});
         mflag[tgt] = 1'b1;
      end else begin
         repeat (waits) exp_q.push_back('{1'b0, 1'b0, 1'b0, 32'h0});
         if (err) begin
            exp_q.push_back('{1'b0, 1'b1, 1'b0, 32'h0});
            exp_q.push_back('{1'b1, 1'b1, 1'b0, 32'h0});
         end else begin
            exp_q.push_back('{1'b1, 1'b0, 1'b1, rd});
         end
      end
   endtask

   // Behaviour of the addressed slave in data-phase cycle n.
   task automatic drive_slaves(input int s, input int n, input int waits, input bit err,
                               input logic [31:0] rd);
      idle_slaves();
      if (s >= 0) begin
         bus.s_hrdata_in[s*DW +: DW] = rd;
         if (n < waits) begin
            bus.s_hready_in[s] = 1'b0;
         end else if (err && n == waits) begin
            bus.s_hready_in[s] = 1'b0;
            bus.s_hresp_in[s]  = 1'b1;
         end else if (err && n == waits + 1) begin
            bus.s_hresp_in[s]  = 1'b1;
         end
      end
   endtask

   task automatic xfer(input string nm, input logic [31:0] addr, input bit wr,
                       input int waits, input bit err, input logic [31:0] rd);
      int         tgt;
      logic [1:0] exp_sel;
      tgt     = model_target(addr);
      exp_sel = (tgt < 0) ? 2'b00 : ((tgt == 0) ? 2'b01 : 2'b10);
      bus.m_haddr_in  = addr;
      bus.m_htrans_in = 2'b10;
      bus.m_hwrite_in = wr;
      idle_slaves();
      #1;
      chk({nm, " hsel"}, 32'(bus.s_hsel_out), 32'(exp_sel));
      chk({nm, " addr_hready"}, 32'(bus.m_hready_out), 32'h1);
      model_resp(tgt, waits, err, rd);
      for (int n = 0; n < exp_q.size(); n++) begin
         @(posedge clk);
         #1;
         if (n == 0) begin
            bus.m_htrans_in = 2'b00;
            bus.m_hwdata_in = ~addr;
         end
         drive_slaves(tgt, n, waits, err, rd);
         #1;
         chk({nm, " hready"}, 32'(bus.m_hready_out), 32'(exp_q[n].hready));
         chk({nm, " s_hready"}, 32'(bus.s_hready_out), 32'(exp_q[n].hready));
         chk({nm, " hresp"}, 32'(bus.m_hresp_out), 32'(exp_q[n].hresp));
         if (exp_q[n].rd_care) chk({nm, " hrdata"}, bus.m_hrdata_out, exp_q[n].rdata);
      end
      @(posedge clk);
      #1;
      idle_slaves();
      chk({nm, " flags"}, 32'(bus.timeout_flag_out), 32'(mflag));
   endtask

   task automatic random_phase(input int count);
      logic [31:0] a;
      int          waits;
      bit          err;
      for (int k = 0; k < count; k++) begin
         case ($urandom_range(0, 5))
            0:       a = 32'($urandom_range(0, 32'hFFFF));
            1:       a = 32'h0001_0000 + 32'($urandom_range(0, 32'hFFF));
            2:       a = 32'h0001_1000 + 32'($urandom_range(0, 32'hFFFF));
            3:       a = 32'h0000_FFFF + 32'($urandom_range(0, 1));
            4:       a = 32'h0001_0FFF + 32'($urandom_range(0, 1));
            default: a = $urandom;
         endcase
         waits = ($urandom_range(0, 9) == 0) ? 8 + $urandom_range(0, 3) : $urandom_range(0, 3);
         err   = ($urandom_range(0, 3) == 0);
         xfer("rand", a, bit'($urandom_range(0, 1)), waits, err, $urandom);
      end
   endtask

   dec_vec_t dec_vecs [8];

   initial begin
      dec_vecs[0] = '{32'h0000_0040, 32'h0001_0000, 2'b01};
      dec_vecs[1] = '{32'h0000_FFFF, 32'h0001_0000, 2'b01};
      dec_vecs[2] = '{32'h0001_0000, 32'h0001_0000, 2'b10};
      dec_vecs[3] = '{32'h0001_0FFF, 32'h0001_0000, 2'b10};
      dec_vecs[4] = '{32'h0001_1000, 32'h0001_0000, 2'b00};
      dec_vecs[5] = '{32'h8000_0000, 32'h0001_0000, 2'b00};
      dec_vecs[6] = '{32'h0000_9000, 32'h0000_8000, 2'b01};
      dec_vecs[7] = '{32'h0001_0004, 32'h0000_8000, 2'b10};

      base[0] = 32'h0000_0000; last[0] = 32'h0000_FFFF;
      base[1] = 32'h0001_0000; last[1] = 32'h0001_0FFF;
      mflag   = '0;
      apply_ranges();
      bus.m_haddr_in     = '0;
      bus.m_htrans_in    = 2'b00;
      bus.m_hwrite_in    = 1'b0;
      bus.m_hsize_in     = 3'b010;
      bus.m_hburst_in    = 3'b000;
      bus.m_hprot_in     = 4'b0011;
      bus.m_hmastlock_in = 1'b0;
      bus.m_hwdata_in    = '0;
      idle_slaves();
      rst_n = 1'b0;
      #1;
      chk("reset hready", 32'(bus.m_hready_out), 32'h1);
      chk("reset hresp", 32'(bus.m_hresp_out), 32'h0);
      chk("reset hrdata", bus.m_hrdata_out, 32'h0);
      chk("reset flags", 32'(bus.timeout_flag_out), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Combinational decode and broadcast table
      for (int i = 0; i < 8; i++) begin
         base[1] = dec_vecs[i].base1;
         apply_ranges();
         bus.m_haddr_in  = dec_vecs[i].addr;
         bus.m_hwdata_in = $urandom;
         bus.m_hprot_in  = 4'(i);
         #1;
         chk($sformatf("decode[%0d] hsel", i), 32'(bus.s_hsel_out), 32'(dec_vecs[i].hsel));
         chk($sformatf("decode[%0d] haddr", i), bus.s_haddr_out, dec_vecs[i].addr);
         chk($sformatf("decode[%0d] hwdata", i), bus.s_hwdata_out, bus.m_hwdata_in);
         chk($sformatf("decode[%0d] hprot", i), 32'(bus.s_hprot_out), 32'(i));
      end
      base[1] = 32'h0001_0000;
      apply_ranges();
      @(posedge clk);
      #1;

      // Directed transfers
      xfer("read_1wait", 32'h0000_0040, 1'b0, 1, 1'b0, 32'hDEAD_BEEF);
      xfer("write_s1", 32'h0001_0FFC, 1'b1, 0, 1'b0, 32'h0);
      xfer("read_unmapped", 32'h0001_1000, 1'b0, 0, 1'b0, 32'h0);

      bus.m_haddr_in  = 32'h8000_0000;
      bus.m_htrans_in = 2'b00;
      for (int n = 0; n < 2; n++) begin
         @(posedge clk);
         #1;
         chk("idle_default hready", 32'(bus.m_hready_out), 32'h1);
         chk("idle_default hresp", 32'(bus.m_hresp_out), 32'h0);
      end

      xfer("wait7_ok", 32'h0000_1000, 1'b0, 7, 1'b0, 32'h1234_5678);
      xfer("wait7_err", 32'h0000_2000, 1'b0, 7, 1'b1, 32'h0);
      xfer("hang_s1", 32'h0001_0000, 1'b0, 100, 1'b0, 32'hCAFE_F00D);
      chk("quarantine flag", 32'(bus.timeout_flag_out), 32'h2);
      xfer("after_quarantine", 32'h0001_0004, 1'b0, 0, 1'b0, 32'h5555_AAAA);

      // Asynchronous reset during a slave0 wait state
      bus.m_haddr_in  = 32'h0000_0040;
      bus.m_htrans_in = 2'b10;
      @(posedge clk);
      #1;
      bus.m_htrans_in    = 2'b00;
      bus.s_hready_in[0] = 1'b0;
      #1;
      chk("rst_mid wait_hready", 32'(bus.m_hready_out), 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid hready", 32'(bus.m_hready_out), 32'h1);
      chk("rst_mid hresp", 32'(bus.m_hresp_out), 32'h0);
      chk("rst_mid flags", 32'(bus.timeout_flag_out), 32'h0);
      mflag = '0;
      idle_slaves();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      random_phase(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
